prime_index_decoder: RTL and testbench
======================================

// Module: prime_index_decoder
// PURPOSE
// Inverse of the index->prime lookup table: given an 8-bit value, computes sequentially
// whether it is prime and its index in the prime sequence (2->0, 3->1, ..., 251->53).
// Non-primes return the count of primes below the value.
// Sits beside the lookup table in the TinyTapeout user design so firmware/bench can round-trip.
// Iterative trial division (one subtract per cycle) keeps area small; latency is data-dependent.
// PARAMETERS
// W_VAL     8   width of value input (fixed 8 for this tile; primes < 2^8)
// W_IDX     6   width of index output (54 primes below 256 fit in 6 bits)
// PORTS
// clk       in   1      rising-edge clock
// rst_n     in   1      asynchronous active-low reset
// start     in   1      request; sampled only in IDLE; captures value
// value     in   8      number to decode; sampled on accepted start only
// busy      out  1      high from cycle after accepted start until done cycle (inclusive)
// done      out  1      one-cycle pulse: result registers valid this cycle and onward
// is_prime  out  1      1 if captured value is prime
// index     out  6      prime: its 0-based index; non-prime: number of primes < value
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE; busy, done, is_prime, index = 0.
// - Regs: v (target), n (candidate), d (divisor), r (remainder), cnt (primes found).
// - IDLE: start=1 -> v<=value, n<=2, cnt<=0, busy<=1 -> NEXT. Else hold results.
// - NEXT: if n > v or v < 2 -> FINISH. Else d<=2 -> TEST.
// - TEST: if d*d > n (n prime) -> PRIME. Else r<=n -> MOD.
// - MOD: while r >= d: r<=r-d (1 cycle each). When r < d: r==0 -> COMPOSITE,
//   else d<=d+1 -> TEST.
// - PRIME: if n==v -> is_prime<=1, FINISH; else cnt<=cnt+1, n<=n+1 -> NEXT.
// - COMPOSITE: if n==v -> is_prime<=0, FINISH; else n<=n+1 -> NEXT.
// - FINISH: index<=cnt, done<=1 for this one cycle, busy<=0 next cycle -> IDLE.
// - is_prime clears to 0 on each accepted start; index keeps old value until FINISH.
// - Widths: d*d computed in 9 bits (d <= 16, 16*16=256 > 255, no overflow);
//   n is 9 bits so n = v+1 is representable when v=255.
// - Bounds: v=0 or 1 -> is_prime=0, index=0. v=255 -> is_prime=0, index=54.
// - Worst-case latency (v=255) < 2^17 cycles. Every input finishes; no hang.
// - start while busy: ignored; value is not re-sampled. start on FINISH cycle: ignored.
//   start held high: a new run is accepted on the first IDLE cycle after done.
// - rst_n low mid-run: run aborted, all outputs 0, IDLE. No done pulse for aborted run.
// - Result = table inverse: for k in 0..53, value=prime(k) -> is_prime=1, index=k.
// TESTING
// 1 reset; value=2, pulse start -> one done pulse; is_prime=1, index=0; busy low after done.
// 2 sweep value 0..255 vs software model -> e.g. 251 -> (1,53); 97 -> (1,24);
//   100 -> (0,25); 0/1 -> (0,0); 255 -> (0,54); each done within 2^17 cycles.
// 3 value=13, start; mid-run change value to 4 and pulse start again -> result (1,5);
//   exactly one done pulse.
// 4 value=200, start; rst_n low at cycle 50 -> outputs 0 immediately, no done;
//   release, value=7 -> (1,3).
// 5 start held high with value=3 -> back-to-back runs, each (1,1);
//   done pulses separated by >= 1 IDLE cycle.
// 6 round-trip: for k=0..53 feed prime(k) from the lookup table -> index==k, is_prime=1.

Source files
------------

// File: rtl/prime_index_decoder.sv
// Sequential inverse of the prime lookup table: reports whether a captured 8-bit value
// is prime and how many primes lie below it, using one trial-division subtract per cycle.
module prime_index_decoder #(
  parameter int W_VAL = 8,
  parameter int W_IDX = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W_VAL-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             is_prime,
  output logic [W_IDX-1:0] index
);

  localparam int WN = W_VAL + 1;      // candidate/remainder width: holds v+1
  localparam int WD = W_VAL / 2 + 1;  // divisor width: reaches sqrt(2^W_VAL)

  typedef enum logic [2:0] {
    S_IDLE, S_NEXT, S_TEST, S_MOD, S_PRIME, S_COMP, S_FINISH
  } state_t;

  state_t           state;
  logic [W_VAL-1:0] v;
  logic [WN-1:0]    n;
  logic [WD-1:0]    d;
  logic [WN-1:0]    r;
  logic [W_IDX-1:0] cnt;

  logic [WN-1:0] d_ext, dd, v_ext;
  assign d_ext = WN'(d);
  assign dd    = d_ext * d_ext;
  assign v_ext = {1'b0, v};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      v        <= '0;
      n        <= '0;
      d        <= '0;
      r        <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      is_prime <= 1'b0;
      index    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            v        <= value;
            n        <= WN'(2);
            cnt      <= '0;
            busy     <= 1'b1;
            is_prime <= 1'b0;
            state    <= S_NEXT;
          end
        end
        // done is raised on entry to FINISH so it overlaps the last busy cycle
        S_NEXT: begin
          if (n > v_ext || v < W_VAL'(2)) begin
            index <= cnt;
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            d     <= WD'(2);
            state <= S_TEST;
          end
        end
        S_TEST: begin
          if (dd > n) state <= S_PRIME;
          else begin
            r     <= n;
            state <= S_MOD;
          end
        end
        S_MOD: begin
          if (r >= d_ext) r <= r - d_ext;
          else if (r == '0) state <= S_COMP;
          else begin
            d     <= d + WD'(1);
            state <= S_TEST;
          end
        end
        S_PRIME: begin
          if (n == v_ext) begin
            is_prime <= 1'b1;
            index    <= cnt;
            done     <= 1'b1;
            state    <= S_FINISH;
          end else begin
            cnt   <= cnt + W_IDX'(1);
            n     <= n + WN'(1);
            state <= S_NEXT;
          end
        end
        S_COMP: begin
          if (n == v_ext) begin
            is_prime <= 1'b0;
            index    <= cnt;
            done     <= 1'b1;
            state    <= S_FINISH;
          end else begin
            n     <= n + WN'(1);
            state <= S_NEXT;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_index_decoder.sv
// Directed bench for prime_index_decoder: arithmetic prime model checked on every done
// pulse and idle cycle, plus literal expectations for known table entries.
module tb_prime_index_decoder;
  localparam int TMO = 1 << 17;

  logic       clk, rst_n, start;
  logic [7:0] value;
  logic       busy, done, is_prime;
  logic [5:0] index;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic       exp_p = 1'b0;
  logic [5:0] exp_i = '0;

  prime_index_decoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy), .done(done), .is_prime(is_prime), .index(index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_prime(input int x);
    if (x < 2) return 1'b0;
    for (int k = 2; k < x; k++) if (x % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_index(input int x);
    int c = 0;
    for (int k = 0; k < x; k++) if (m_prime(k)) c++;
    return c;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Compare process: result on done, hold value while idle, pulse shape.
  logic       prev_done = 1'b0;
  logic       last_p = 1'b0;
  logic [5:0] last_i = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
      last_p    = 1'b0;
      last_i    = '0;
    end else begin
      if (prev_done) chk("busy_after_done", int'(busy), 0);
      if (done) begin
        chk("done_is_prime", int'(is_prime), int'(exp_p));
        chk("done_index", int'(index), int'(exp_i));
        chk("busy_on_done", int'(busy), 1);
        chk("done_one_cycle", int'(prev_done), 0);
        done_cnt++;
        last_p = exp_p;
        last_i = exp_i;
      end else if (!busy) begin
        chk("hold_is_prime", int'(is_prime), int'(last_p));
        chk("hold_index", int'(index), int'(last_i));
      end
      prev_done = done;
    end
  end

  task automatic set_exp(input int x);
    exp_p = m_prime(x);
    exp_i = 6'(m_index(x));
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk({nm, "_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic run(input int x);
    int dc;
    @(negedge clk);
    dc = done_cnt;
    value = 8'(x);
    start = 1'b1;
    set_exp(x);
    @(negedge clk);
    start = 1'b0;
    wait_done("run");
    chk("one_done_per_run", done_cnt - dc, 1);
  endtask

  int primes[16] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53};

  initial begin
    int dc;
    rst_n = 1'b0;
    start = 1'b0;
    value = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_is_prime", int'(is_prime), 0);
    chk("rst_index", int'(index), 0);
    rst_n = 1'b1;

    // basic run
    run(2);
    chk("v2_prime", int'(is_prime), 1);
    chk("v2_index", int'(index), 0);
    chk("v2_busy", int'(busy), 0);

    // directed sweep with literal anchors
    run(0);   chk("v0_prime", int'(is_prime), 0);  chk("v0_index", int'(index), 0);
    run(1);   chk("v1_prime", int'(is_prime), 0);  chk("v1_index", int'(index), 0);
    run(4);   chk("v4_prime", int'(is_prime), 0);  chk("v4_index", int'(index), 2);
    run(9);   chk("v9_index", int'(index), 4);
    run(97);  chk("v97_prime", int'(is_prime), 1); chk("v97_index", int'(index), 24);
    run(100); chk("v100_prime", int'(is_prime), 0); chk("v100_index", int'(index), 25);
    run(255); chk("v255_prime", int'(is_prime), 0); chk("v255_index", int'(index), 54);

    // start while busy is ignored
    @(negedge clk);
    dc = done_cnt;
    value = 8'd13; start = 1'b1; set_exp(13);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    value = 8'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("restart");
    repeat (20) @(negedge clk);
    chk("v13_prime", int'(is_prime), 1);
    chk("v13_index", int'(index), 5);
    chk("restart_one_done", done_cnt - dc, 1);

    // reset mid-run
    @(negedge clk);
    dc = done_cnt;
    value = 8'd200; start = 1'b1; set_exp(200);
    @(negedge clk); start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_is_prime", int'(is_prime), 0);
    chk("abort_index", int'(index), 0);
    repeat (2) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 0);
    rst_n = 1'b1;
    run(7);
    chk("v7_prime", int'(is_prime), 1);
    chk("v7_index", int'(index), 3);

    // start held high: back-to-back runs
    @(negedge clk);
    dc = done_cnt;
    value = 8'd3; start = 1'b1; set_exp(3);
    repeat (40) @(negedge clk);
    start = 1'b0;
    begin
      int n = 0;
      while ((busy || done) && n < TMO) begin @(negedge clk); n++; end
      if (busy || done) chk("held_timeout", 0, 1);
    end
    @(negedge clk);
    chk("held_multi_done", int'(done_cnt - dc >= 3), 1);
    chk("held_is_prime", int'(is_prime), 1);
    chk("held_index", int'(index), 1);

    // round trip against the lookup table
    foreach (primes[k]) begin
      run(primes[k]);
      chk("rt_index", int'(index), k);
      chk("rt_is_prime", int'(is_prime), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
